scan_sel_gen: RTL and testbench

Upstream sequencer for the 3-bit decoder stage. It walks a programmable set of enabled channels in ascending index order and drives the 3-bit select code the decoder turns into a one-hot line. It holds each channel for a programmable dwell time and inserts a one-cycle break-before-make gap between channels, so no two decoded lines are ever qualified in adjacent cycles. It runs either one pass per start (single mode) or repeating passes (continuous mode).

---
 rtl/scan_sel_gen.sv | 167 ++++++++++++++++
 tb/tb_scan_sel_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/scan_sel_gen.sv
// scan_sel_gen
//   Walks the enabled channels in ascending index order and drives the 3-bit
//   select code for the downstream decoder. Each channel is held for dwell+1
//   cycles, then a one-cycle gap (sel_valid low) separates it from the next
//   channel. Runs one pass per start, or loops continuously when cont=1.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      scan request, sampled only while idle
//   stop       abort, highest priority
//   cont       1 = continuous passes, 0 = single pass (latched at start)
//   chan_mask  per-channel enable, bit i = channel i (latched at start)
//   dwell      per-channel hold length minus one (latched at start)
//   sel        select code to the decoder
//   sel_valid  sel qualified
//   busy       scan in progress
//   done       one-cycle pulse at the end of a single pass (or empty-mask start)
//   wrap       one-cycle pulse in the gap before a continuous pass restarts
module scan_sel_gen #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {IDLE, DWELL, GAP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_d;
    logic               sel_valid_d, busy_d, done_d, wrap_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Lowest set bit of m (0 when m is empty; callers check for that).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (m[i-1]) idx = 3'(i - 1);
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit of m strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (m[i-1] && ((i - 1) > 32'(cur))) r = {1'b1, 3'(i - 1)};
        end
        return r;
    endfunction

    logic [3:0] above;
    logic [2:0] first_idx;

    always_comb begin
        above     = next_above(mask_q, sel);
        first_idx = lowest_set(mask_q);
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (chan_mask != '0) begin
                        mask_d      = chan_mask;
                        dwell_d     = dwell;
                        cont_d      = cont;
                        sel_d       = lowest_set(chan_mask);
                        cnt_d       = '0;
                        state_d     = DWELL;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == dwell_q) begin
                    if (above[3]) begin
                        state_d = GAP;
                        busy_d  = 1'b1;
                    end else if (cont_q) begin
                        state_d = GAP;
                        busy_d  = 1'b1;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d       = cnt_q + DWELL_W'(1);
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    // The registered wrap flag marks a gap that restarts the pass.
                    sel_d       = wrap ? first_idx : above[2:0];
                    cnt_d       = '0;
                    state_d     = DWELL;
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            mask_q    <= '0;
            dwell_q   <= '0;
            cont_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            wrap      <= wrap_d;
            mask_q    <= mask_d;
            dwell_q   <= dwell_d;
            cont_q    <= cont_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen
//   Directed bench for scan_sel_gen: a table of per-cycle {inputs, expected
//   outputs} records, followed by hand-written asynchronous-reset and
//   maximum-dwell sequences.
module tb_scan_sel_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] chan_mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic       wrap;

    int checks;
    int failures;

    scan_sel_gen #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .chan_mask (chan_mask),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before an edge, outputs expected after that edge.
    typedef struct {
        string      tag;
        logic       start;
        logic       stop;
        logic       cont;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [2:0] sel;
        logic       sv;
        logic       busy;
        logic       done;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input string tag, input logic st, input logic sp, input logic ct,
                     input logic [7:0] m, input logic [7:0] d,
                     input logic [2:0] es, input logic esv, input logic eb,
                     input logic ed, input logic ew);
        vec_t r;
        r.tag = tag; r.start = st; r.stop = sp; r.cont = ct; r.mask = m; r.dwell = d;
        r.sel = es; r.sv = esv; r.busy = eb; r.done = ed; r.wrap = ew;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s {sel,valid,busy,done,wrap} got=%b_%b exp=%b_%b",
                     name, act[6:4], act[3:0], exp[6:4], exp[3:0]);
        end
    endtask

    function automatic logic [6:0] outs();
        return {sel, sel_valid, busy, done, wrap};
    endfunction

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; cont = 1'b0; chan_mask = '0; dwell = '0;
    endtask

    initial begin
        int cyc;
        int valid_cnt;
        logic seen_done;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        check("reset_state", outs(), 7'b000_0000);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", outs(), 7'b000_0000);

        // Full pass, no hold: sel k valid at cycle 2k+1, gaps at even cycles.
        v("full_c1", 1, 0, 0, 8'hFF, 8'd0, 3'd0, 1, 1, 0, 0);
        for (int c = 2; c <= 15; c++) begin
            if (c % 2 == 1) v("full_valid", 0, 0, 0, 8'h00, 8'd0, 3'((c - 1) / 2), 1, 1, 0, 0);
            else            v("full_gap",   0, 0, 0, 8'h00, 8'd0, 3'(c / 2 - 1), 0, 1, 0, 0);
        end
        v("full_done", 0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 1, 0);
        v("full_after", 0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0, 0);

        // Sparse mask, then the same scan with start/mask/dwell/cont disturbed at cycle 5.
        for (int pass = 0; pass < 2; pass++) begin
            v("sparse_c1", 1, 0, 0, 8'hA4, 8'd2, 3'd2, 1, 1, 0, 0);
            v("sparse_c2", 0, 0, 0, 8'hA4, 8'd2, 3'd2, 1, 1, 0, 0);
            v("sparse_c3", 0, 0, 0, 8'hA4, 8'd2, 3'd2, 1, 1, 0, 0);
            v("sparse_gap4", 0, 0, 0, 8'hA4, 8'd2, 3'd2, 0, 1, 0, 0);
            if (pass == 0) v("sparse_c5", 0, 0, 0, 8'hA4, 8'd2, 3'd5, 1, 1, 0, 0);
            else           v("busy_ign_c5", 1, 0, 1, 8'hFF, 8'd0, 3'd5, 1, 1, 0, 0);
            v("sparse_c6", 0, 0, 0, 8'hFF, 8'd0, 3'd5, 1, 1, 0, 0);
            v("sparse_c7", 0, 0, 0, 8'hFF, 8'd0, 3'd5, 1, 1, 0, 0);
            v("sparse_gap8", 0, 0, 0, 8'h00, 8'd0, 3'd5, 0, 1, 0, 0);
            v("sparse_c9", 0, 0, 0, 8'h00, 8'd0, 3'd7, 1, 1, 0, 0);
            v("sparse_c10", 0, 0, 0, 8'h00, 8'd0, 3'd7, 1, 1, 0, 0);
            v("sparse_c11", 0, 0, 0, 8'h00, 8'd0, 3'd7, 1, 1, 0, 0);
            v("sparse_done12", 0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 1, 0);
        end

        // Empty mask: done only, sel held.
        v("empty_done", 1, 0, 0, 8'h00, 8'd3, 3'd7, 0, 0, 1, 0);
        v("empty_after", 0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0, 0);

        // Continuous single channel, stop sampled at edge 5.
        v("cont1_c1", 1, 0, 1, 8'h01, 8'd1, 3'd0, 1, 1, 0, 0);
        v("cont1_c2", 0, 0, 0, 8'h00, 8'd0, 3'd0, 1, 1, 0, 0);
        v("cont1_wrap3", 0, 0, 0, 8'h00, 8'd0, 3'd0, 0, 1, 0, 1);
        v("cont1_c4", 0, 0, 0, 8'h00, 8'd0, 3'd0, 1, 1, 0, 0);
        v("cont1_stop5", 0, 1, 0, 8'h00, 8'd0, 3'd0, 0, 0, 0, 0);
        v("cont1_idle6", 0, 0, 0, 8'h00, 8'd0, 3'd0, 0, 0, 0, 0);

        // Continuous wrap from 7 back to 0, then stop in DWELL.
        v("cont81_c1", 1, 0, 1, 8'h81, 8'd0, 3'd0, 1, 1, 0, 0);
        v("cont81_gap2", 0, 0, 0, 8'h00, 8'd0, 3'd0, 0, 1, 0, 0);
        v("cont81_c3", 0, 0, 0, 8'h00, 8'd0, 3'd7, 1, 1, 0, 0);
        v("cont81_wrap4", 0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 1, 0, 1);
        v("cont81_c5", 0, 0, 0, 8'h00, 8'd0, 3'd0, 1, 1, 0, 0);
        v("cont81_gap6", 0, 0, 0, 8'h00, 8'd0, 3'd0, 0, 1, 0, 0);
        v("cont81_c7", 0, 0, 0, 8'h00, 8'd0, 3'd7, 1, 1, 0, 0);
        v("cont81_stop8", 0, 1, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0, 0);

        // start and stop together: nothing happens.
        v("startstop", 1, 1, 0, 8'hFF, 8'd0, 3'd7, 0, 0, 0, 0);
        v("startstop_after", 0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            start = tbl[i].start; stop = tbl[i].stop; cont = tbl[i].cont;
            chan_mask = tbl[i].mask; dwell = tbl[i].dwell;
            @(posedge clk); #1;
            check(tbl[i].tag, outs(),
                  {tbl[i].sel, tbl[i].sv, tbl[i].busy, tbl[i].done, tbl[i].wrap});
        end
        idle_inputs();

        // Asynchronous reset between edges while in DWELL.
        start = 1'b1; chan_mask = 8'h30; dwell = 8'd5;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        check("pre_reset_dwell", outs(), 7'b100_1100);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 7'b000_0000);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release_idle", outs(), 7'b000_0000);

        // Maximum dwell on one channel: 256 valid cycles, then done.
        start = 1'b1; chan_mask = 8'h10; dwell = 8'hFF;
        @(posedge clk); #1;
        idle_inputs();
        valid_cnt = 0;
        seen_done = 1'b0;
        cyc = 0;
        while (!seen_done && cyc < 400) begin
            if (sel_valid) valid_cnt++;
            if (done) seen_done = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("maxdwell_done_seen", {6'd0, seen_done}, 7'd1);
        check("maxdwell_valid_cycles", 7'(valid_cnt >> 2), 7'd64);
        check("maxdwell_valid_lsb", 7'(valid_cnt & 3), 7'd0);
        check("maxdwell_done_state", outs(), 7'b100_0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
